// File: rtl/avr_prog_rom_bridge_if.sv
// Byte-wide program ROM bus with level request and one-cycle ack.
// master: rom_addr/rom_req out, rom_ack/rom_data in; slave: the reverse.
interface avr_prog_rom_bridge_if;
  logic [16:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [7:0]  rom_data;

  modport master (
    output rom_addr, rom_req,
    input  rom_ack, rom_data
  );

  modport slave (
    input  rom_addr, rom_req,
    output rom_ack, rom_data
  );
endinterface

// File: rtl/avr_prog_rom_bridge.sv
// Fetch-port responder: 16-bit words from a byte ROM, one-word cache, timeout.
// Ports: CLK, RST, prog_addr, flush, prog_data, instr_valid, stall, fetch_err, rom.
module avr_prog_rom_bridge #(
  parameter int          TIMEOUT  = 16,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] prog_addr,
  input  logic        flush,
  output logic [15:0] prog_data,
  output logic        instr_valid,
  output logic        stall,
  output logic        fetch_err,
  avr_prog_rom_bridge_if.master rom
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] req_addr, req_addr_n;
  logic [15:0] tag, tag_n;
  logic [7:0]  lo_buf, lo_buf_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] data_n;
  logic        cache_valid, cv_n;
  logic        err_n;
  // flush seen while a read is in flight: result is stored but not trusted
  logic        fpend, fpend_n;
  logic        hit;

  assign hit         = cache_valid & (prog_addr == tag) & ~flush;
  assign instr_valid = (state == IDLE) & hit;
  assign stall       = ~instr_valid;

  assign rom.rom_req  = (state != IDLE);
  assign rom.rom_addr = {req_addr, state == RD_HI};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      req_addr    <= 16'h0000;
      tag         <= 16'h0000;
      lo_buf      <= 8'h00;
      cnt         <= 8'h00;
      prog_data   <= NOP_WORD;
      cache_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fpend       <= 1'b0;
    end else begin
      state       <= state_n;
      req_addr    <= req_addr_n;
      tag         <= tag_n;
      lo_buf      <= lo_buf_n;
      cnt         <= cnt_n;
      prog_data   <= data_n;
      cache_valid <= cv_n;
      fetch_err   <= err_n;
      fpend       <= fpend_n;
    end
  end

  always_comb begin
    state_n    = state;
    req_addr_n = req_addr;
    tag_n      = tag;
    lo_buf_n   = lo_buf;
    cnt_n      = cnt;
    data_n     = prog_data;
    cv_n       = cache_valid;
    err_n      = fetch_err;
    fpend_n    = fpend;
    unique case (state)
      IDLE: begin
        if (flush) cv_n = 1'b0;
        if (!hit) begin
          req_addr_n = prog_addr;
          cnt_n      = 8'h00;
          fpend_n    = 1'b0;
          state_n    = RD_LO;
        end
      end
      RD_LO, RD_HI: begin
        if (flush) fpend_n = 1'b1;
        if (rom.rom_ack) begin
          cnt_n = 8'h00;
          if (state == RD_LO) begin
            lo_buf_n = rom.rom_data;
            state_n  = RD_HI;
          end else begin
            data_n  = {rom.rom_data, lo_buf};
            tag_n   = req_addr;
            cv_n    = ~(fpend | flush);
            state_n = IDLE;
          end
        end else if (cnt == TO_LAST) begin
          // ROM never answered: hand the CPU a NOP instead of deadlocking
          data_n  = NOP_WORD;
          tag_n   = req_addr;
          cv_n    = ~(fpend | flush);
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avr_prog_rom_bridge.sv
// Bench for avr_prog_rom_bridge: vector table, corner sequences, random fetches.
// Drives fetch port and a programmable-latency ROM model through the interface.
module tb_avr_prog_rom_bridge;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prog_addr;
  logic        flush;
  logic [15:0] prog_data;
  logic        instr_valid;
  logic        stall;
  logic        fetch_err;

  avr_prog_rom_bridge_if rif ();

  avr_prog_rom_bridge #(
    .TIMEOUT  (TO),
    .NOP_WORD (16'h0000)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .prog_addr   (prog_addr),
    .flush       (flush),
    .prog_data   (prog_data),
    .instr_valid (instr_valid),
    .stall       (stall),
    .fetch_err   (fetch_err),
    .rom         (rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [15:0] w;
    if (a == 16'h0000) return 16'hE0A5;
    w = a * 16'h9E37;
    return w ^ 16'h3C5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // ROM model: ack after lo_wait/hi_wait request cycles; negative = never
  int          lo_wait = 0;
  int          hi_wait = 0;
  int          rcnt = 0;
  logic [16:0] last_addr = '0;
  logic        last_req = 1'b0;

  initial begin
    int w;
    logic [15:0] wd;
    rif.rom_ack  = 1'b0;
    rif.rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rif.rom_req && last_req && rif.rom_addr == last_addr) rcnt++;
      else rcnt = 0;
      last_addr = rif.rom_addr;
      last_req  = rif.rom_req;
      w  = rif.rom_addr[0] ? hi_wait : lo_wait;
      wd = word_of(rif.rom_addr[16:1]);
      rif.rom_ack  = rif.rom_req && w >= 0 && rcnt == w;
      rif.rom_data = rif.rom_ack ? (rif.rom_addr[0] ? wd[15:8] : wd[7:0]) : 8'h00;
    end
  end

  logic [16:0] seen[$];

  // Called at negedge+1; returns at negedge+1 of the first valid cycle.
  task automatic run_fetch(input logic [15:0] a, input int lw, input int hw,
                           output int stalls);
    bit done = 0;
    prog_addr = a;
    lo_wait   = lw;
    hi_wait   = hw;
    seen.delete();
    stalls = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (instr_valid) done = 1;
      else begin
        stalls++;
        if (rif.rom_req && (seen.size() == 0 || seen[$] != rif.rom_addr))
          seen.push_back(rif.rom_addr);
        @(negedge clk);
      end
    end
    if (!done) chk("fetch_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    int          lw;
    int          hw;
    logic [15:0] data;
    int          stalls;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  function automatic bit tmo(input int w);
    return (w < 0 || w >= TO);
  endfunction

  function automatic int phase(input int w);
    return tmo(w) ? TO : w + 1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got 0 want 1");
    $fatal(1);
  end

  initial begin
    int st;
    bit ok;
    logic [15:0] m_tag;
    logic [15:0] m_data;
    bit          m_valid;
    bit          m_err;

    tbl[0] = '{16'h0000, 0, 0, 16'hE0A5, 3, 1'b0};
    tbl[1] = '{16'h0000, 0, 0, 16'hE0A5, 0, 1'b0};
    tbl[2] = '{16'h0123, 4, 4, word_of(16'h0123), 11, 1'b0};
    tbl[3] = '{16'hFFFF, 0, 2, word_of(16'hFFFF), 5, 1'b0};
    tbl[4] = '{16'h0007, -1, 0, 16'h0000, 17, 1'b1};
    tbl[5] = '{16'h0007, 0, 0, 16'h0000, 0, 1'b1};
    tbl[6] = '{16'h0010, 1, -1, 16'h0000, 19, 1'b1};
    tbl[7] = '{16'h0020, 15, 15, word_of(16'h0020), 33, 1'b1};

    rst = 1'b1;
    flush = 1'b0;
    prog_addr = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_prog_data", prog_data, 16'h0000);
    chk("rst_rom_req", rif.rom_req, 0);
    chk("rst_rom_addr", rif.rom_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_stall", stall, 1);
    chk("rst_err", fetch_err, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_fetch(tbl[i].addr, tbl[i].lw, tbl[i].hw, st);
      chk($sformatf("v%0d_stalls", i), st, tbl[i].stalls);
      chk($sformatf("v%0d_data", i), prog_data, tbl[i].data);
      chk($sformatf("v%0d_err", i), fetch_err, tbl[i].err);
      chk($sformatf("v%0d_nbytes", i), seen.size(),
          tbl[i].stalls == 0 ? 0 : (tmo(tbl[i].lw) ? 1 : 2));
      if (seen.size() >= 1)
        chk($sformatf("v%0d_addr_lo", i), seen[0], {tbl[i].addr, 1'b0});
      if (seen.size() >= 2)
        chk($sformatf("v%0d_addr_hi", i), seen[1], {tbl[i].addr, 1'b1});
      if (i == 0) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          chk("hold_req", rif.rom_req, 0);
          chk("hold_valid", instr_valid, 1);
          chk("hold_data", prog_data, 16'hE0A5);
        end
      end
    end

    // flush while hitting
    run_fetch(16'h0003, 0, 0, st);
    chk("fh_valid", instr_valid, 1);
    flush = 1'b1;
    #1;
    chk("fh_stall_now", stall, 1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fh_stall_next", stall, 1);
    chk("fh_req", rif.rom_req, 1);
    chk("fh_addr", rif.rom_addr, 17'h00006);
    run_fetch(16'h0003, 0, 0, st);
    chk("fh_data", prog_data, word_of(16'h0003));
    chk("fh_hi_addr", seen.size() >= 2 ? seen[1] : 17'h1_FFFF, 17'h00007);

    // flush during the high-byte read
    prog_addr = 16'h0009;
    lo_wait = 0;
    hi_wait = 2;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (rif.rom_req && rif.rom_addr[0]) begin ok = 1; break; end
      @(negedge clk);
      #1;
    end
    chk("fr_reach_hi", ok, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (!rif.rom_req) begin ok = 1; break; end
      @(negedge clk);
      #1;
    end
    chk("fr_reach_idle", ok, 1);
    chk("fr_word", prog_data, word_of(16'h0009));
    chk("fr_not_valid", instr_valid, 0);
    @(negedge clk);
    #1;
    chk("fr_refetch_req", rif.rom_req, 1);
    chk("fr_refetch_addr", rif.rom_addr, 17'h00012);
    run_fetch(16'h0009, 0, 0, st);
    chk("fr_data", prog_data, word_of(16'h0009));

    // prog_addr moves while a read is in flight
    prog_addr = 16'h0040;
    lo_wait = 3;
    hi_wait = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    run_fetch(16'h0041, 3, 0, st);
    chk("ac_nbytes", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("ac_b0", seen[0], 17'h00080);
      chk("ac_b1", seen[1], 17'h00081);
      chk("ac_b2", seen[2], 17'h00082);
      chk("ac_b3", seen[3], 17'h00083);
    end
    chk("ac_data", prog_data, word_of(16'h0041));

    // reset with a high-byte ack still pending
    prog_addr = 16'h0055;
    lo_wait = 0;
    hi_wait = 3;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (rif.rom_req && rif.rom_addr[0]) begin ok = 1; break; end
      @(negedge clk);
      #1;
    end
    chk("rr_reach_hi", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rr_req", rif.rom_req, 0);
    chk("rr_data", prog_data, 16'h0000);
    chk("rr_valid", instr_valid, 0);
    chk("rr_err", fetch_err, 0);
    rst = 1'b0;

    // random fetches against a word-level cache model
    do_reset();
    m_valid = 0;
    m_tag = '0;
    m_data = '0;
    m_err = 0;
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      int lw, hw, exp_st;
      bit to_lo, to_any;
      a = 16'($urandom_range(0, 7));
      if (n % 9 == 8) a = 16'hFFFF;
      lw = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, 5));
      hw = $urandom_range(0, 9) == 0 ? 16 : int'($urandom_range(0, 5));
      if (n % 11 == 5) lw = 15;
      run_fetch(a, lw, hw, st);
      if (m_valid && m_tag == a) begin
        exp_st = 0;
      end else begin
        to_lo  = tmo(lw);
        to_any = to_lo || tmo(hw);
        exp_st = 1 + phase(lw) + (to_lo ? 0 : phase(hw));
        m_data  = to_any ? 16'h0000 : word_of(a);
        m_tag   = a;
        m_valid = 1;
        m_err   = m_err | to_any;
      end
      chk($sformatf("r%0d_stalls", n), st, exp_st);
      chk($sformatf("r%0d_data", n), prog_data, m_data);
      chk($sformatf("r%0d_err", n), fetch_err, m_err);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
